seq_alu: RTL

Registered, parametrised ALU with a start/done handshake. It executes every legacy 4-bit ALU mode in one cycle and adds iterative unsigned multiply and divide. It sits between the Control Unit, which drives `Start`/`Mode`, and the Status Register and data memory, which consume `Flags` and `Out`. Results and flags are held until the next operation completes.

---
 rtl/seq_alu.sv | 243 ++++++++++++++++++++++++
 1 files changed

// File: rtl/seq_alu.sv
// seq_alu: registered ALU with a Start/Done handshake.
// All legacy 4-bit ALU modes complete in one cycle. Define SEQ_ALU_MULDIV_EN to
// add iterative unsigned multiply (0x10) and divide (0x11). Without it those
// modes behave as undefined modes and Busy/OutHi are tied low.
module seq_alu #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             Start,
  input  logic [4:0]       Mode,
  input  logic [3:0]       CFlags,
  input  logic [WIDTH-1:0] Operand1,
  input  logic [WIDTH-1:0] Operand2,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] Out,
  output logic [WIDTH-1:0] OutHi,
  output logic [3:0]       Flags
);

  localparam int unsigned SHW  = $clog2(WIDTH);
  localparam int unsigned SHW1 = SHW + 1;
  localparam int unsigned WP1  = WIDTH + 1;
  localparam int unsigned FC   = 2;
  localparam int unsigned FO   = 0;

  logic [SHW-1:0]   amt;
  logic [WIDTH-1:0] add_x;
  logic [WIDTH-1:0] add_y;
  logic             add_ci;
  logic [WIDTH:0]   add_sum;
  logic [WIDTH-1:0] sc_out;
  logic             sc_c;
  logic             sc_o;
  logic [3:0]       sc_flags;

  logic [WIDTH-1:0] out_q, out_d;
  logic [3:0]       flags_q, flags_d;
  logic             done_q, done_d;

  // Z and S are always recomputed, so only C and O of CFlags are consumed
  logic unused_cflags;
  assign unused_cflags = ^{CFlags[3], CFlags[1]};

  assign amt = Operand1[SHW-1:0];

  // Adder operand selection; subtraction is X + ~Y + 1
  always_comb begin
    add_x  = Operand1;
    add_y  = Operand2;
    add_ci = 1'b0;
    case (Mode[3:0])
      4'h1: begin add_y = ~Operand2; add_ci = 1'b1; end
      4'h7: begin add_x = Operand2; add_y = ~Operand1; add_ci = 1'b1; end
      4'h8: begin add_x = Operand2; add_y = WIDTH'(1); end
      4'h9: begin add_x = Operand2; add_y = ~WIDTH'(1); add_ci = 1'b1; end
      4'hF: begin add_x = '0; add_y = ~Operand2; add_ci = 1'b1; end
      default: ;
    endcase
  end

  assign add_sum = {1'b0, add_x} + {1'b0, add_y} + WP1'(add_ci);

  // Single-cycle result and flags; undefined modes return B with C/O passed through
  always_comb begin
    sc_out = Operand2;
    sc_c   = CFlags[FC];
    sc_o   = CFlags[FO];
    if (!Mode[4]) begin
      case (Mode[3:0])
        4'h0, 4'h1, 4'h7, 4'h8, 4'h9, 4'hF: begin
          sc_out = add_sum[WIDTH-1:0];
          sc_c   = add_sum[WIDTH];
          sc_o   = (add_x[WIDTH-1] == add_y[WIDTH-1]) &&
                   (add_sum[WIDTH-1] != add_x[WIDTH-1]);
        end
        4'h2: sc_out = Operand1;
        4'h3: sc_out = Operand2;
        4'h4: sc_out = Operand1 & Operand2;
        4'h5: sc_out = Operand1 | Operand2;
        4'h6: sc_out = Operand1 ^ Operand2;
        4'hA: sc_out = (Operand2 << amt) | (Operand2 >> (SHW1'(WIDTH) - SHW1'(amt)));
        4'hB: sc_out = (Operand2 >> amt) | (Operand2 << (SHW1'(WIDTH) - SHW1'(amt)));
        4'hC: sc_out = Operand2 << amt;
        4'hD: sc_out = Operand2 >> amt;
        4'hE: sc_out = WIDTH'($signed(Operand2) >>> amt);
        default: ;
      endcase
    end
    sc_flags = {sc_out == '0, sc_c, sc_out[WIDTH-1], sc_o};
  end

`ifdef SEQ_ALU_MULDIV_EN
  typedef enum logic {S_IDLE, S_RUN} state_t;

  state_t           state_q, state_d;
  logic [SHW-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [WIDTH-1:0] opb_q, opb_d;
  logic             is_div_q, is_div_d;
  logic             busy_q, busy_d;
  logic [WIDTH-1:0] outhi_q, outhi_d;
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_rem;
  logic [WIDTH-1:0] div_diff;
  logic             div_ge;
  logic [WIDTH-1:0] step_hi;
  logic [WIDTH-1:0] step_lo;
  logic             muldiv_mode;

  assign muldiv_mode = (Mode == 5'h10) || (Mode == 5'h11);

  // One shift-add multiply step or one restoring-divide step on {hi,lo}.
  // A zero divisor always "fits", leaving quotient all ones and the dividend
  // shifted into hi, which is exactly the divide-by-zero result.
  always_comb begin
    mul_sum  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opb_q} : '0);
    div_rem  = {hi_q, lo_q[WIDTH-1]};
    div_ge   = div_rem >= {1'b0, opb_q};
    div_diff = div_rem[WIDTH-1:0] - opb_q;
    if (is_div_q) begin
      step_hi = div_ge ? div_diff : div_rem[WIDTH-1:0];
      step_lo = {lo_q[WIDTH-2:0], div_ge};
    end else begin
      step_hi = mul_sum[WIDTH:1];
      step_lo = {mul_sum[0], lo_q[WIDTH-1:1]};
    end
  end

  // Next state, result capture and handshake
  always_comb begin
    out_d    = out_q;
    flags_d  = flags_q;
    done_d   = 1'b0;
    state_d  = state_q;
    cnt_d    = cnt_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    opb_d    = opb_q;
    is_div_d = is_div_q;
    busy_d   = busy_q;
    outhi_d  = outhi_q;
    case (state_q)
      S_IDLE: begin
        if (Start) begin
          if (muldiv_mode) begin
            state_d  = S_RUN;
            busy_d   = 1'b1;
            cnt_d    = '0;
            hi_d     = '0;
            lo_d     = Operand1;
            opb_d    = Operand2;
            is_div_d = Mode[0];
          end else begin
            out_d   = sc_out;
            outhi_d = '0;
            flags_d = sc_flags;
            done_d  = 1'b1;
          end
        end
      end
      S_RUN: begin
        hi_d  = step_hi;
        lo_d  = step_lo;
        cnt_d = cnt_q + SHW'(1);
        if (cnt_q == SHW'(WIDTH - 1)) begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
          cnt_d   = '0;
          done_d  = 1'b1;
          out_d   = step_lo;
          outhi_d = step_hi;
          if (is_div_q) begin
            flags_d = {step_lo == '0, opb_q == '0, step_lo[WIDTH-1], 1'b0};
          end else begin
            flags_d = {{step_hi, step_lo} == '0, step_hi != '0, step_lo[WIDTH-1], 1'b0};
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end
`else
  // Next state, result capture and handshake
  always_comb begin
    out_d   = out_q;
    flags_d = flags_q;
    done_d  = 1'b0;
    if (Start) begin
      out_d   = sc_out;
      flags_d = sc_flags;
      done_d  = 1'b1;
    end
  end
`endif

  // State and output registers; reset aborts any operation in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q    <= '0;
      flags_q  <= '0;
      done_q   <= 1'b0;
`ifdef SEQ_ALU_MULDIV_EN
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      opb_q    <= '0;
      is_div_q <= 1'b0;
      busy_q   <= 1'b0;
      outhi_q  <= '0;
`endif
    end else begin
      out_q    <= out_d;
      flags_q  <= flags_d;
      done_q   <= done_d;
`ifdef SEQ_ALU_MULDIV_EN
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      opb_q    <= opb_d;
      is_div_q <= is_div_d;
      busy_q   <= busy_d;
      outhi_q  <= outhi_d;
`endif
    end
  end

  assign Out   = out_q;
  assign Flags = flags_q;
  assign Done  = done_q;
`ifdef SEQ_ALU_MULDIV_EN
  assign Busy  = busy_q;
  assign OutHi = outhi_q;
`else
  assign Busy  = 1'b0;
  assign OutHi = '0;
`endif

endmodule
